// File: rtl/fifo_byte_packer_if.sv
// Bundles the FIFO read port, the flush request and the packed output stream.
// The master side is the packer; the slave side is the FIFO plus downstream sink.
interface fifo_byte_packer_if #(
    parameter int NB = 4
);
    logic              fifo_empty;
    logic [7:0]        fifo_data;
    logic              fifo_rd_en;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [8*NB-1:0]   m_data;
    logic [NB-1:0]     m_keep;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  flush,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output m_keep
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output flush,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  m_keep
    );
endinterface

// File: rtl/fifo_byte_packer.sv
// Pops bytes from a synchronous FIFO with one-cycle read latency and packs NB
// of them little-endian into one word on a valid/ready stream. A flush emits
// the partially packed word with a byte-enable mask.
module fifo_byte_packer #(
    parameter int NB = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_byte_packer_if.master bus
);
    localparam int            CW     = $clog2(NB + 1);
    localparam logic [CW:0]   LVL_NB = (CW + 1)'(NB);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     byte_cnt, byte_cnt_nxt;
    logic              pending, pending_nxt;
    logic              flush_req, flush_req_nxt;
    logic              flush_clr;
    logic              rd_en;
    logic [CW:0]       fill_lvl;
    logic [8*NB-1:0]   acc, acc_nxt;
    logic [8*NB-1:0]   m_data_q, m_data_nxt;
    logic [NB-1:0]     m_keep_q, m_keep_nxt;
    logic              m_valid_q, m_valid_nxt;

    // Bytes already captured plus the one still in flight from the FIFO.
    assign fill_lvl = {1'b0, byte_cnt} + {{CW{1'b0}}, pending};

    // State and datapath registers; everything clears on a synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            byte_cnt  <= '0;
            pending   <= 1'b0;
            flush_req <= 1'b0;
            // NOTE: the accumulator is reset too, because a partial flush
            // relies on unpopulated upper lanes reading as zero.
            acc       <= '0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            state     <= state_nxt;
            byte_cnt  <= byte_cnt_nxt;
            pending   <= pending_nxt;
            flush_req <= flush_req_nxt;
            acc       <= acc_nxt;
            m_data_q  <= m_data_nxt;
            m_keep_q  <= m_keep_nxt;
            m_valid_q <= m_valid_nxt;
        end
    end

    // Next-state, read request, byte capture, word emission and flush handling.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        acc_nxt      = acc;
        m_data_nxt   = m_data_q;
        m_keep_nxt   = m_keep_q;
        m_valid_nxt  = m_valid_q;
        flush_clr    = 1'b0;
        rd_en        = 1'b0;

        case (state)
            FILL: begin
                rd_en = !bus.fifo_empty && !flush_req && (fill_lvl < LVL_NB);
                if (pending) begin
                    for (int i = 0; i < NB; i++) begin
                        if (byte_cnt == CW'(i)) begin
                            acc_nxt[8*i +: 8] = bus.fifo_data;
                        end
                    end
                    if (byte_cnt == CW'(NB - 1)) begin
                        m_data_nxt   = acc_nxt;
                        m_keep_nxt   = '1;
                        m_valid_nxt  = 1'b1;
                        byte_cnt_nxt = '0;
                        acc_nxt      = '0;
                        state_nxt    = HOLD;
                    end else begin
                        byte_cnt_nxt = byte_cnt + CW'(1);
                    end
                end else if (flush_req) begin
                    // A pending byte is always captured before the flush acts.
                    flush_clr = 1'b1;
                    if (byte_cnt != '0) begin
                        m_data_nxt = acc;
                        for (int i = 0; i < NB; i++) begin
                            m_keep_nxt[i] = (CW'(i) < byte_cnt);
                        end
                        m_valid_nxt  = 1'b1;
                        byte_cnt_nxt = '0;
                        acc_nxt      = '0;
                        state_nxt    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_nxt = 1'b0;
                    state_nxt   = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // A read issued this cycle returns data next cycle; a new flush pulse
    // wins over clearing an old request in the same cycle.
    assign pending_nxt   = rd_en;
    assign flush_req_nxt = bus.flush | (flush_req & ~flush_clr);

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_keep     = m_keep_q;
endmodule

// File: tb/tb_fifo_byte_packer.sv
// Self-checking bench: behavioural FIFO with one-cycle read latency, a
// scoreboard of expected words and a monitor for the stream and invariants.
module tb_fifo_byte_packer;
    localparam int NB = 4;

    typedef struct {
        logic [8*NB-1:0] data;
        logic [NB-1:0]   keep;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_byte_packer_if #(.NB(NB)) bus ();

    fifo_byte_packer #(.NB(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int   viol         = 0;
    int   rd_pulses    = 0;
    int   valid_cycles = 0;

    // Behavioural FIFO: writer advances wr_ptr, reader advances rd_ptr.
    logic [7:0] fmem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_data <= fmem[rd_ptr[7:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [8*NB-1:0] d, input logic [NB-1:0] k);
        exp_t e;
        e.data = d;
        e.keep = k;
        exp_q.push_back(e);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !bus.m_valid) break;
            tick(1);
        end
        check("drain_timeout", (exp_q.size() == 0 && !bus.m_valid), 1);
    endtask

    // Stream monitor and invariant checks, sampled mid-cycle.
    logic            prev_stall = 1'b0;
    logic [8*NB-1:0] prev_data;
    logic [NB-1:0]   prev_keep;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.fifo_rd_en && bus.fifo_empty) viol++;
            if (bus.fifo_rd_en && bus.m_valid) viol++;
            if (bus.fifo_rd_en) rd_pulses++;
            if (bus.m_valid) valid_cycles++;
            if (prev_stall) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_data", bus.m_data, prev_data);
                check("stall_keep", bus.m_keep, prev_keep);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_data", bus.m_data, e.data);
                    check("word_keep", bus.m_keep, e.keep);
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_keep  = bus.m_keep;
        end
    end

    initial begin
        int rd0;
        int v0;
        logic seen;

        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;
        rst         = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_valid", bus.m_valid, 0);
        check("rst_data", bus.m_data, 0);
        check("rst_keep", bus.m_keep, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);

        // Full word with exact latency: m_valid appears 5 edges after the
        // bytes become available and lasts one cycle with m_ready high.
        bus.m_ready = 1'b1;
        rd0 = rd_pulses;
        expect_word(32'h44332211, 4'hF);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick(4);
        check("lat_not_yet", bus.m_valid, 0);
        tick(1);
        check("lat_valid", bus.m_valid, 1);
        check("lat_data", bus.m_data, 32'h44332211);
        tick(1);
        check("lat_drop", bus.m_valid, 0);
        drain();
        check("t1_reads", rd_pulses - rd0, 4);
        check("t1_rd_idle", bus.fifo_rd_en, 0);
        check("t1_empty", bus.fifo_empty, 1);

        // Backpressure: first word held for 5 cycles with no reads.
        bus.m_ready = 1'b0;
        expect_word(32'h04030201, 4'hF);
        expect_word(32'h08070605, 4'hF);
        for (int b = 1; b <= 8; b++) push(8'(b));
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.m_valid) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        check("t2_valid_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_data", bus.m_data, 32'h04030201);
            check("t2_hold_rd_en", bus.fifo_rd_en, 0);
            tick(1);
        end
        bus.m_ready = 1'b1;
        drain();

        // Partial flush after two bytes, then an empty flush.
        expect_word(32'h0000BBAA, 4'b0011);
        push(8'hAA); push(8'hBB);
        tick(4);
        pulse_flush();
        drain();
        v0 = valid_cycles;
        pulse_flush();
        tick(6);
        check("t3_empty_flush", valid_cycles - v0, 0);

        // Flush arriving while the second read is still in flight.
        expect_word(32'h0000BBAA, 4'b0011);
        push(8'hAA); push(8'hBB);
        tick(2);
        pulse_flush();
        drain();

        // Long empty period, then a single byte.
        rd0 = rd_pulses;
        tick(20);
        check("t5_no_reads", rd_pulses - rd0, 0);
        push(8'h5A);
        tick(5);
        check("t5_one_read", rd_pulses - rd0, 1);
        expect_word(32'h0000005A, 4'b0001);
        pulse_flush();
        drain();

        // Reset mid-word discards the partial bytes.
        push(8'h12); push(8'h34);
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_valid", bus.m_valid, 0);
        check("t6_rst_keep", bus.m_keep, 0);
        expect_word(32'h88776655, 4'hF);
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        drain();

        tick(2);
        check("invariant_violations", viol, 0);
        check("scoreboard_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
